// File: rtl/leitor_seg_pkg.sv
// leitor_seg_pkg: shared constants, segment table and FSM states for the seven-segment reader
package leitor_seg_pkg;
  localparam int num_digits = 4;
  localparam logic [6:0] seg_table [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };
  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;
endpackage

// File: rtl/seg_pattern_decode.sv
// seg_pattern_decode: active-high a..g pattern to hex nibble, nibble 0 with hit=0 on a miss
module seg_pattern_decode
  import leitor_seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       hit
);
  always_comb begin
    nibble = 4'd0;
    hit = 1'b0;
    for (int i = 0; i < 16; i++)
      if (seg_table[i] == pattern) begin
        nibble = 4'(i);
        hit = 1'b1;
      end
  end
endmodule

// File: rtl/leitor_seg2bin.sv
// leitor_seg2bin: samples a multiplexed 4-digit seven-segment bus and rebuilds
// the displayed hex value as a valid/ready frame
module leitor_seg2bin
  import leitor_seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  an_n,
  input  logic [7:0]  seg_n,
  output logic [15:0] out_data,
  output logic [3:0]  out_dp,
  output logic [3:0]  out_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overrun
);
  logic [11:0] s1, s2, prev;
  state_t st;
  logic [7:0] cnt;
  logic sel, hit, full, acc, acc_dp, acc_err;
  logic [1:0] dig, acc_dig;
  logic [3:0] nib, acc_nib;
  logic [15:0] slot_data;
  logic [num_digits-1:0] slot_dp, slot_err, mask;
  always_comb begin
    sel = $countones(~s2[11:8]) == 1;
    dig = !s2[8] ? 2'd0 : !s2[9] ? 2'd1 : !s2[10] ? 2'd2 : 2'd3;
    full = &mask;
  end
  seg_pattern_decode u_dec (.pattern(~s2[7:1]), .nibble(nib), .hit(hit));
  // a digit is accepted once, on the sample that makes the run STABLE_CYCLES long
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      prev <= '0;
      st <= IDLE;
      cnt <= 8'd0;
      acc <= 1'b0;
      acc_dig <= 2'd0;
      acc_nib <= 4'd0;
      acc_dp <= 1'b0;
      acc_err <= 1'b0;
    end else begin
      s1 <= {an_n, seg_n};
      s2 <= s1;
      prev <= s2;
      acc <= 1'b0;
      if (st != IDLE && s2 == prev) begin
        if (st == SETTLE) begin
          cnt <= cnt + 8'd1;
          if (cnt + 8'd1 == 8'(STABLE_CYCLES)) begin
            st <= HELD;
            acc <= 1'b1;
            acc_dig <= dig;
            acc_nib <= nib;
            acc_dp <= ~s2[0];
            acc_err <= ~hit;
          end
        end
      end else begin
        st <= sel ? SETTLE : IDLE;
        cnt <= sel ? 8'd1 : 8'd0;
      end
    end
  end
  // a full mask is flushed one cycle later, delivered or dropped as overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_data <= 16'd0;
      slot_dp <= '0;
      slot_err <= '0;
      mask <= '0;
      out_data <= 16'd0;
      out_dp <= 4'd0;
      out_err <= 4'd0;
      out_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (acc) begin
        slot_data[{acc_dig, 2'b00} +: 4] <= acc_nib;
        slot_dp[acc_dig] <= acc_dp;
        slot_err[acc_dig] <= acc_err;
      end
      mask <= (full ? 4'd0 : mask) | ({3'd0, acc} << acc_dig);
      overrun <= full && out_valid && !out_ready;
      if (full && (!out_valid || out_ready)) begin
        out_data <= slot_data;
        out_dp <= slot_dp;
        out_err <= slot_err;
        out_valid <= 1'b1;
      end else if (!full && out_ready)
        out_valid <= 1'b0;
    end
  end
endmodule

// File: doc/leitor_seg2bin.md
LEITOR_SEG2BIN -- requirements
Module: leitor_seg2bin

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4: consecutive identical synchronised samples (2..255) required before a digit is accepted.
REQ-002 SHALL have port clk  input  1: single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-004 SHALL have port an_n  input  4: digit enables of a multiplexed 4-digit display bus, active-low, bit i = digit i.
REQ-005 SHALL have port seg_n  input  8: segment lines, active-low, bit7=a … bit1=g, bit0=dp.
REQ-006 SHALL have port out_data  output  16: captured hex value, digit i in bits [4i+3:4i].
REQ-007 SHALL have port out_dp  output  4: decimal point state per digit, 1 = lit.
REQ-008 SHALL have port out_err  output  4: per digit, 1 = pattern not in decode table.
REQ-009 SHALL have port out_valid  output  1: frame available.
REQ-010 SHALL have port out_ready  input  1: consumer accepts frame.
REQ-011 SHALL have port overrun  output  1: one-cycle pulse when a completed frame is dropped.

Function
REQ-012 SHALL pass an_n and seg_n through a two-flop synchroniser before any use.
REQ-013 SHALL treat a sample as selectable only when exactly one an_n bit is 0.
REQ-014 SHALL run FSM IDLE/SETTLE/HELD: IDLE->SETTLE on selectable sample; SETTLE counts samples equal to previous one; SETTLE->HELD and accept digit when count reaches STABLE_CYCLES; any change of {an_n,seg_n} returns to SETTLE (selectable) or IDLE (not selectable) with count restarted at 1 or 0.
REQ-015 SHALL accept a digit exactly once per HELD period, regardless of how long the pattern persists.
REQ-016 SHALL decode seg_n[7:1] (inverted to active-high) with the table 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B A=77 b=1F C=4E d=3D E=4F F=47 (hex, bits a..g).
REQ-017 SHALL on unmatched pattern store nibble 0 and set that digit's error bit; dp stored as ~seg_n[0].
REQ-018 SHALL keep a 4-bit capture mask; re-capture of an already-set digit in the same frame overwrites its slot.
REQ-019 SHALL, on the cycle after the mask becomes 1111, load out_data/out_dp/out_err, assert out_valid, clear mask.
REQ-020 SHALL hold out_valid and outputs stable until out_valid && out_ready; out_valid deasserts next cycle.
REQ-021 SHALL, if a frame completes while out_valid=1 and out_ready=0, drop the new frame, pulse overrun, keep old outputs.
REQ-022 SHALL, if a frame completes in the same cycle as a transfer, load the new frame and keep out_valid=1 with no overrun.
REQ-023 SHALL have latency of 2 + STABLE_CYCLES + 1 cycles from a stable input change to slot capture.

Reset
REQ-024 SHALL, on rst_n=0 at any time, asynchronously clear synchroniser, FSM to IDLE, counter, mask, out_data=0, out_dp=0, out_err=0, out_valid=0, overrun=0.
REQ-025 SHALL discard any partial frame on reset mid-operation; first frame after release requires all 4 digits.

Structure
REQ-026 SHALL place the 16-entry segment table, STATE enum and digit count constant in package leitor_seg_pkg.
REQ-027 SHALL implement table lookup as combinational sub-module seg_pattern_decode (pattern in; nibble, hit out).

Verification
REQ-028 SHALL check: digits 0..3 show 1,2,3,4 for 8 cycles each, out_ready=1 -> out_data=16'h4321, out_err=0, out_valid one cycle.
REQ-029 SHALL check: digit 2 pattern held only 3 cycles (STABLE_CYCLES=4) -> no capture, no out_valid until a valid 4+ cycle dwell.
REQ-030 SHALL check: digit 1 shows a=b only (7'h60) -> out_err=4'b0010, nibble 1 = 0.
REQ-031 SHALL check: out_ready=0, two full frames -> second frame drops, overrun one pulse, out_data keeps first value.
REQ-032 SHALL check: an_n=4'b0000 or 4'b1111 for 20 cycles -> FSM stays IDLE, mask unchanged.
REQ-033 SHALL check: rst_n low after 3 digits captured -> all outputs 0 immediately; next frame needs all 4 digits.
